// File: rtl/am2302_pkg.sv
// am2302_pkg
//   Shared definitions for the AM2302 frame post-processor: FSM state
//   encoding, byte/field offsets inside the 40-bit sensor frame, decode
//   limits and the sign-magnitude to two's-complement temperature helper.
//   No ports (package).
package am2302_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUM    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_DECODE = 3'd3,
    ST_AVG    = 3'd4,
    ST_OUT    = 3'd5
  } state_e;

  // Byte offsets inside the frame (LSB position of each byte)
  localparam int HUM_HI_LSB = 32;
  localparam int HUM_LO_LSB = 24;
  localparam int TMP_HI_LSB = 16;
  localparam int TMP_LO_LSB = 8;
  localparam int CSUM_LSB   = 0;

  // 16-bit field offsets
  localparam int HUM_LSB  = 24;
  localparam int TEMP_LSB = 8;

  localparam logic [15:0] HUM_MAX       = 16'd1000;
  localparam logic [15:0] TEMP_NEG_ZERO = 16'h8000;

  // Sensor reports temperature as sign + 15-bit magnitude; negative zero maps to 0.
  function automatic logic signed [15:0] sm_to_tc(input logic [15:0] sm);
    logic signed [15:0] mag;
    mag = $signed({1'b0, sm[14:0]});
    if (sm == TEMP_NEG_ZERO) begin
      return 16'sd0;
    end else if (sm[15]) begin
      return -mag;
    end else begin
      return mag;
    end
  endfunction

endpackage

// File: rtl/am2302_frame_proc_if.sv
// am2302_frame_proc_if
//   Frame hand-off from the AM2302 single-wire master to the frame
//   post-processor.
//   frame_valid : one-cycle strobe, frame_data valid in the same cycle
//   frame_data  : 40-bit captured frame
//   frame_ready : processor idle and able to accept a frame
//   master modport = frame source, slave modport = frame processor.
interface am2302_frame_proc_if;
  logic        frame_valid;
  logic [39:0] frame_data;
  logic        frame_ready;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/am2302_avg_ring.sv
// am2302_avg_ring
//   One signed 17-bit moving-average channel: a ring of 2^AVG_LOG2 samples,
//   a running sum and a write pointer.
//   clk, rst    : clock, synchronous active-high reset (clears ring, sum, wp)
//   prime_i     : fill every entry with sample_i and set sum = sample<<AVG_LOG2
//   update_i    : replace the oldest entry with sample_i and adjust the sum
//   sample_i    : new signed sample
//   avg_o       : floor(sum / 2^AVG_LOG2)
module am2302_avg_ring #(
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prime_i,
  input  logic               update_i,
  input  logic signed [16:0] sample_i,
  output logic signed [16:0] avg_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 17 + AVG_LOG2;

  logic signed [16:0]   ring_q [DEPTH];
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_d;
  logic [AVG_LOG2-1:0]  wp_q;
  logic signed [SW-1:0] sample_ext_s;
  logic signed [SW-1:0] oldest_ext_s;

  assign sample_ext_s = {{AVG_LOG2{sample_i[16]}}, sample_i};
  assign oldest_ext_s = {{AVG_LOG2{ring_q[wp_q][16]}}, ring_q[wp_q]};

  // Next running sum: prime seeds it, update swaps oldest for newest.
  always_comb begin
    sum_d = sum_q;
    if (prime_i) begin
      sum_d = sample_ext_s <<< AVG_LOG2;
    end else if (update_i) begin
      sum_d = sum_q + sample_ext_s - oldest_ext_s;
    end else begin
      sum_d = sum_q;
    end
  end

  // Ring storage, running sum and write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      wp_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= 17'sd0;
      end
    end else begin
      sum_q <= sum_d;
      if (prime_i) begin
        wp_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ring_q[i] <= sample_i;
        end
      end else if (update_i) begin
        ring_q[wp_q] <= sample_i;
        wp_q         <= wp_q + AVG_LOG2'(1);
      end
    end
  end

  // Dropping the low AVG_LOG2 bits of a two's-complement sum is an
  // arithmetic shift, i.e. a floor division by the depth.
  assign avg_o = sum_q[SW-1:AVG_LOG2];

endmodule

// File: rtl/am2302_frame_proc.sv
// am2302_frame_proc
//   Post-processes captured AM2302 frames: checksum verification, humidity
//   clamp, sign-magnitude temperature decode, optional moving average and a
//   hysteretic threshold alarm.
//   Build option: define AM2302_FRAME_AVG_EN to build the moving average
//   (latency 9); without it the decoded values go straight out (latency 8).
//   clk, rst        : clock, synchronous active-high reset
//   frm_if (slave)  : frame_valid / frame_data in, frame_ready out
//   hum_out_o       : humidity, unsigned 0.1 %RH
//   temp_out_o      : temperature, two's complement 0.1 degC
//   result_valid_o  : one-cycle pulse when hum_out_o/temp_out_o update
//   crc_err_o       : last frame failed its checksum
//   err_count_o     : saturating checksum failure count
//   alarm_o         : threshold alarm with release hysteresis
module am2302_frame_proc
  import am2302_pkg::*;
#(
  parameter int                 AVG_LOG2 = 2,
  parameter logic [15:0]        HUM_HI   = 16'd800,
  parameter logic signed [15:0] TEMP_HI  = 16'sd350,
  parameter logic [15:0]        HYST     = 16'd20
) (
  input  logic               clk,
  input  logic               rst,
  am2302_frame_proc_if.slave frm_if,
  output logic [15:0]        hum_out_o,
  output logic [15:0]        temp_out_o,
  output logic               result_valid_o,
  output logic               crc_err_o,
  output logic [7:0]         err_count_o,
  output logic               alarm_o
);

  if ((AVG_LOG2 < 32'sd1) || (AVG_LOG2 > 32'sd4)) begin : g_bad_avg_log2
    $error("AVG_LOG2 must be in 1..4");
  end

  // Thresholds widened to 18-bit signed so the subtraction cannot wrap.
  localparam logic signed [17:0] HUM_SET_TH  = $signed({2'b00, HUM_HI});
  localparam logic signed [17:0] HUM_CLR_TH  = HUM_SET_TH - $signed({2'b00, HYST});
  localparam logic signed [17:0] TEMP_SET_TH = $signed({{2{TEMP_HI[15]}}, TEMP_HI});
  localparam logic signed [17:0] TEMP_CLR_TH = TEMP_SET_TH - $signed({2'b00, HYST});

  state_e             state_q;
  logic [39:0]        frm_q;
  logic [1:0]         idx_q;
  logic [7:0]         sum_q;
  logic [15:0]        hum_dec_q;
  logic signed [15:0] temp_dec_q;
  logic               frame_ready_q;
  logic [15:0]        hum_out_q;
  logic [15:0]        temp_out_q;
  logic               result_valid_q;
  logic               crc_err_q;
  logic [7:0]         err_count_q;
  logic               alarm_q;

  logic [7:0]         sum_byte_s;
  logic [15:0]        hum_raw_s;
  logic signed [16:0] hum_res_s;
  logic signed [16:0] temp_res_s;
  logic signed [17:0] hum_cmp_s;
  logic signed [17:0] temp_cmp_s;
  logic               alarm_next_s;

`ifdef AM2302_FRAME_AVG_EN
  logic               primed_q;
  logic               ring_prime_s;
  logic               ring_update_s;
  logic signed [16:0] hum_avg_s;
  logic signed [16:0] temp_avg_s;

  // The first good frame after reset seeds both rings; later ones slide them.
  assign ring_prime_s  = (state_q == ST_AVG) && !primed_q;
  assign ring_update_s = (state_q == ST_AVG) && primed_q;

  am2302_avg_ring #(.AVG_LOG2(AVG_LOG2)) u_hum_ring (
    .clk      (clk),
    .rst      (rst),
    .prime_i  (ring_prime_s),
    .update_i (ring_update_s),
    .sample_i ($signed({1'b0, hum_dec_q})),
    .avg_o    (hum_avg_s)
  );

  am2302_avg_ring #(.AVG_LOG2(AVG_LOG2)) u_temp_ring (
    .clk      (clk),
    .rst      (rst),
    .prime_i  (ring_prime_s),
    .update_i (ring_update_s),
    .sample_i ({temp_dec_q[15], temp_dec_q}),
    .avg_o    (temp_avg_s)
  );

  assign hum_res_s  = hum_avg_s;
  assign temp_res_s = temp_avg_s;
`else
  assign hum_res_s  = $signed({1'b0, hum_dec_q});
  assign temp_res_s = {temp_dec_q[15], temp_dec_q};
`endif

  assign hum_raw_s  = frm_q[HUM_LSB +: 16];
  assign hum_cmp_s  = {hum_res_s[16], hum_res_s};
  assign temp_cmp_s = {temp_res_s[16], temp_res_s};

  // Byte added during each SUM cycle: index 0..3 walks bytes 4..1.
  always_comb begin
    sum_byte_s = 8'h00;
    case (idx_q)
      2'd0:    sum_byte_s = frm_q[HUM_HI_LSB +: 8];
      2'd1:    sum_byte_s = frm_q[HUM_LO_LSB +: 8];
      2'd2:    sum_byte_s = frm_q[TMP_HI_LSB +: 8];
      2'd3:    sum_byte_s = frm_q[TMP_LO_LSB +: 8];
      default: sum_byte_s = 8'h00;
    endcase
  end

  // Alarm sets at the threshold and releases only below threshold-HYST on both channels.
  always_comb begin
    alarm_next_s = alarm_q;
    if ((hum_cmp_s >= HUM_SET_TH) || (temp_cmp_s >= TEMP_SET_TH)) begin
      alarm_next_s = 1'b1;
    end else if ((hum_cmp_s < HUM_CLR_TH) && (temp_cmp_s < TEMP_CLR_TH)) begin
      alarm_next_s = 1'b0;
    end else begin
      alarm_next_s = alarm_q;
    end
  end

  // Frame-processing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      frm_q          <= 40'h0;
      idx_q          <= 2'd0;
      sum_q          <= 8'h00;
      hum_dec_q      <= 16'd0;
      temp_dec_q     <= 16'sd0;
      frame_ready_q  <= 1'b1;
      hum_out_q      <= 16'd0;
      temp_out_q     <= 16'd0;
      result_valid_q <= 1'b0;
      crc_err_q      <= 1'b0;
      err_count_q    <= 8'd0;
      alarm_q        <= 1'b0;
`ifdef AM2302_FRAME_AVG_EN
      primed_q       <= 1'b0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // frame_valid is only honoured here; elsewhere it is ignored.
          if (frm_if.frame_valid) begin
            frm_q         <= frm_if.frame_data;
            idx_q         <= 2'd0;
            sum_q         <= 8'h00;
            frame_ready_q <= 1'b0;
            state_q       <= ST_SUM;
          end
        end
        ST_SUM: begin
          sum_q <= sum_q + sum_byte_s;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sum_q != frm_q[CSUM_LSB +: 8]) begin
            crc_err_q <= 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
            frame_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            crc_err_q <= 1'b0;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          hum_dec_q  <= (hum_raw_s > HUM_MAX) ? HUM_MAX : hum_raw_s;
          temp_dec_q <= sm_to_tc(frm_q[TEMP_LSB +: 16]);
`ifdef AM2302_FRAME_AVG_EN
          state_q    <= ST_AVG;
`else
          state_q    <= ST_OUT;
`endif
        end
`ifdef AM2302_FRAME_AVG_EN
        ST_AVG: begin
          primed_q <= 1'b1;
          state_q  <= ST_OUT;
        end
`endif
        ST_OUT: begin
          hum_out_q      <= hum_res_s[15:0];
          temp_out_q     <= temp_res_s[15:0];
          alarm_q        <= alarm_next_s;
          result_valid_q <= 1'b1;
          frame_ready_q  <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: begin
          frame_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign frm_if.frame_ready = frame_ready_q;
  assign hum_out_o          = hum_out_q;
  assign temp_out_o         = temp_out_q;
  assign result_valid_o     = result_valid_q;
  assign crc_err_o          = crc_err_q;
  assign err_count_o        = err_count_q;
  assign alarm_o            = alarm_q;

endmodule
